// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control definitions for the multicycle RV32I core: FSM state encoding,
// opcode constants and the alu_op / result_src codes consumed by the datapath.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Codes shared with the ALU decoder, which owns srcA/srcB/ctrl selection.
  typedef enum logic [2:0] {
    ALU_ADD     = 3'd0,
    ALU_CMP     = 3'd1,
    ALU_RFUNCT  = 3'd2,
    ALU_IFUNCT  = 3'd3,
    ALU_ADDR    = 3'd4,
    ALU_PCIMM   = 3'd5,
    ALU_PASSIMM = 3'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU    = 2'd0,
    RES_MEM    = 2'd1,
    RES_ALUOUT = 2'd2,
    RES_LINK   = 2'd3
  } result_src_t;

  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return S_MEMADR;
      OP_RTYPE:          return S_EXECR;
      OP_ITYPE:          return S_EXECI;
      OP_BRANCH:         return S_BRANCH;
      OP_JAL:            return S_JUMP;
      OP_JALR:           return S_JALR;
      OP_LUI:            return S_LUI;
      OP_AUIPC:          return S_AUIPC;
      default:           return S_TRAP;
    endcase
  endfunction

  // States whose exit back to FETCH marks a completed instruction.
  function automatic logic is_retire_state(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) ||
           (s == S_BRANCH) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Memory-port handshake between the control FSM (master) and the memory (slave).
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback, drives datapath enables and counts retired instructions.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [6:0]                   opcode,
  input  logic                         br_taken,
  multicycle_control_fsm_if.master     mem,
  output logic                         ir_write,
  output logic                         pc_write,
  output logic                         reg_write,
  output logic [1:0]                   result_src,
  output logic [2:0]                   alu_op,
  output logic                         illegal,
  output logic [CNT_W-1:0]             retired
);

  state_t      r_state;
  state_t      w_next_state;
  alu_op_t     w_alu_op;
  result_src_t w_result_src;
  logic        w_mem_req;
  logic        w_mem_we;
  logic        w_adr_src;
  logic        w_ir_write;
  logic        w_pc_write;
  logic        w_reg_write;
  logic        w_illegal;
  logic        w_retire;
  logic [CNT_W-1:0] r_retired;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_alu_op     = ALU_ADD;
    w_result_src = RES_ALU;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;

    case (r_state)
      S_IDLE: w_next_state = S_FETCH;

      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem.mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = S_DECODE;
        end
      end

      // Branch/jal target is precomputed here so BRANCH and JUMP find it in ALUOut.
      S_DECODE: begin
        w_alu_op     = ALU_PCIMM;
        w_next_state = decode_next(opcode);
      end

      S_MEMADR: begin
        w_alu_op     = ALU_ADDR;
        w_next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (mem.mem_ready) w_next_state = S_MEMWB;
      end

      S_MEMWB: begin
        w_result_src = RES_MEM;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEMWRITE: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_adr_src = 1'b1;
        if (mem.mem_ready) w_next_state = S_FETCH;
      end

      S_EXECR: begin
        w_alu_op     = ALU_RFUNCT;
        w_next_state = S_ALUWB;
      end

      S_EXECI: begin
        w_alu_op     = ALU_IFUNCT;
        w_next_state = S_ALUWB;
      end

      S_LUI: begin
        w_alu_op     = ALU_PASSIMM;
        w_next_state = S_ALUWB;
      end

      S_AUIPC: begin
        w_alu_op     = ALU_PCIMM;
        w_next_state = S_ALUWB;
      end

      S_ALUWB: begin
        w_result_src = RES_ALU;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BRANCH: begin
        w_alu_op     = ALU_CMP;
        w_result_src = RES_ALUOUT;
        w_pc_write   = br_taken;
        w_next_state = S_FETCH;
      end

      S_JALR: begin
        w_alu_op     = ALU_ADDR;
        w_next_state = S_JUMP;
      end

      // ALUOut goes to the PC; the datapath routes the link value to the
      // register file over its own path.
      S_JUMP: begin
        w_result_src = RES_ALUOUT;
        w_pc_write   = 1'b1;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end

      S_TRAP: w_illegal = 1'b1;
    endcase
  end

  assign w_retire = (w_next_state == S_FETCH) && is_retire_state(r_state);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNT_W'(1);
  end

  assign mem.mem_req = w_mem_req;
  assign mem.mem_we  = w_mem_we;
  assign mem.adr_src = w_adr_src;
  assign ir_write    = w_ir_write;
  assign pc_write    = w_pc_write;
  assign reg_write   = w_reg_write;
  assign result_src  = w_result_src;
  assign alu_op      = w_alu_op;
  assign illegal     = w_illegal;
  assign retired     = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-cycle vector table with a
// scoreboard queue, plus hand-written reset-mid-access and counter-wrap sequences.
module tb_multicycle_control_fsm;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] AU  = 7'b0010111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic        bt;
    logic        rdy;
    logic [11:0] exp_o;
    logic [31:0] exp_ret;
  } vec_t;

  logic       clk;
  logic       resetn;
  logic [6:0] opcode;
  logic       br_taken;
  logic       mem_ready;

  logic        ir_write, pc_write, reg_write, illegal;
  logic [1:0]  result_src;
  logic [2:0]  alu_op;
  logic [31:0] retired;

  logic        ir_write4, pc_write4, reg_write4, illegal4;
  logic [1:0]  result_src4;
  logic [2:0]  alu_op4;
  logic [3:0]  retired4;

  multicycle_control_fsm_if m32 ();
  multicycle_control_fsm_if m4 ();
  assign m32.mem_ready = mem_ready;
  assign m4.mem_ready  = mem_ready;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .opcode(opcode), .br_taken(br_taken), .mem(m32),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_op(alu_op), .illegal(illegal), .retired(retired)
  );

  multicycle_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .opcode(opcode), .br_taken(br_taken), .mem(m4),
    .ir_write(ir_write4), .pc_write(pc_write4), .reg_write(reg_write4),
    .result_src(result_src4), .alu_op(alu_op4), .illegal(illegal4), .retired(retired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step   = 0;
  vec_t tbl[$];
  logic [43:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, result_src, alu_op, illegal}
  function automatic logic [11:0] o(input logic req, we, adr, irw, pcw, rw,
                                    input logic [1:0] rs, input logic [2:0] alu,
                                    input logic ill);
    return {req, we, adr, irw, pcw, rw, rs, alu, ill};
  endfunction

  function automatic logic [11:0] outs32();
    return {m32.mem_req, m32.mem_we, m32.adr_src, ir_write, pc_write, reg_write,
            result_src, alu_op, illegal};
  endfunction

  task automatic add(input logic [6:0] op, input logic bt, input logic rdy,
                     input logic [11:0] exp_o, input logic [31:0] ret);
    vec_t v;
    v.op = op; v.bt = bt; v.rdy = rdy; v.exp_o = exp_o; v.exp_ret = ret;
    tbl.push_back(v);
  endtask

  // Drive one cycle of stimulus at the falling edge, sample 1 ns later.
  task automatic step(input vec_t v);
    logic [43:0] exp;
    @(negedge clk);
    opcode    = v.op;
    br_taken  = v.bt;
    mem_ready = v.rdy;
    sb.push_back({v.exp_o, v.exp_ret});
    #1;
    exp = sb.pop_front();
    check($sformatf("vec%0d", n_step), {20'd0, outs32(), retired}, {20'd0, exp});
    n_step++;
  endtask

  task automatic run_table();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("reset_outs", {52'd0, outs32()}, 64'd0);
    check("reset_retired", {32'd0, retired}, 64'd0);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  // One complete zero-wait R-type instruction starting from FETCH.
  task automatic add_rtype(input logic [31:0] ret);
    add(R, 0, 1, o(1,0,0,1,1,0,0,0,0), ret);
    add(R, 0, 1, o(0,0,0,0,0,0,0,5,0), ret);
    add(R, 0, 1, o(0,0,0,0,0,0,0,2,0), ret);
    add(R, 0, 1, o(0,0,0,0,0,1,0,0,0), ret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1; opcode = R; br_taken = 1'b0; mem_ready = 1'b1;
    do_reset();

    // R-type; mem_ready and br_taken wiggled where they must be ignored
    add(R, 0, 1, o(0,0,0,0,0,0,0,0,0), 0);
    add(R, 0, 1, o(1,0,0,1,1,0,0,0,0), 0);
    add(R, 1, 0, o(0,0,0,0,0,0,0,5,0), 0);
    add(R, 1, 0, o(0,0,0,0,0,0,0,2,0), 0);
    add(R, 0, 1, o(0,0,0,0,0,1,0,0,0), 0);
    // load: FETCH wait state, then 3 wait states in MEMREAD
    add(LD, 0, 0, o(1,0,0,0,0,0,0,0,0), 1);
    add(LD, 0, 1, o(1,0,0,1,1,0,0,0,0), 1);
    add(LD, 0, 0, o(0,0,0,0,0,0,0,5,0), 1);
    add(LD, 0, 1, o(0,0,0,0,0,0,0,4,0), 1);
    for (int k = 0; k < 3; k++) add(LD, 0, 0, o(1,0,1,0,0,0,0,0,0), 1);
    add(LD, 0, 1, o(1,0,1,0,0,0,0,0,0), 1);
    add(LD, 0, 0, o(0,0,0,0,0,1,1,0,0), 1);
    // branch not taken, then taken
    add(BR, 0, 1, o(1,0,0,1,1,0,0,0,0), 2);
    add(BR, 1, 1, o(0,0,0,0,0,0,0,5,0), 2);
    add(BR, 0, 1, o(0,0,0,0,0,0,2,1,0), 2);
    add(BR, 1, 1, o(1,0,0,1,1,0,0,0,0), 3);
    add(BR, 1, 1, o(0,0,0,0,0,0,0,5,0), 3);
    add(BR, 1, 1, o(0,0,0,0,1,0,2,1,0), 3);
    // store with one wait state
    add(ST, 0, 1, o(1,0,0,1,1,0,0,0,0), 4);
    add(ST, 0, 1, o(0,0,0,0,0,0,0,5,0), 4);
    add(ST, 0, 1, o(0,0,0,0,0,0,0,4,0), 4);
    add(ST, 0, 0, o(1,1,1,0,0,0,0,0,0), 4);
    add(ST, 0, 1, o(1,1,1,0,0,0,0,0,0), 4);
    // I-type, LUI, AUIPC
    add(I,  0, 1, o(1,0,0,1,1,0,0,0,0), 5);
    add(I,  0, 1, o(0,0,0,0,0,0,0,5,0), 5);
    add(I,  0, 1, o(0,0,0,0,0,0,0,3,0), 5);
    add(I,  0, 1, o(0,0,0,0,0,1,0,0,0), 5);
    add(LU, 0, 1, o(1,0,0,1,1,0,0,0,0), 6);
    add(LU, 0, 1, o(0,0,0,0,0,0,0,5,0), 6);
    add(LU, 0, 1, o(0,0,0,0,0,0,0,6,0), 6);
    add(LU, 0, 1, o(0,0,0,0,0,1,0,0,0), 6);
    add(AU, 0, 1, o(1,0,0,1,1,0,0,0,0), 7);
    add(AU, 0, 1, o(0,0,0,0,0,0,0,5,0), 7);
    add(AU, 0, 1, o(0,0,0,0,0,0,0,5,0), 7);
    add(AU, 0, 1, o(0,0,0,0,0,1,0,0,0), 7);
    // JAL (3 cycles) and JALR (4 cycles)
    add(JL, 0, 1, o(1,0,0,1,1,0,0,0,0), 8);
    add(JL, 0, 1, o(0,0,0,0,0,0,0,5,0), 8);
    add(JL, 0, 1, o(0,0,0,0,1,1,2,0,0), 8);
    add(JR, 0, 1, o(1,0,0,1,1,0,0,0,0), 9);
    add(JR, 0, 1, o(0,0,0,0,0,0,0,5,0), 9);
    add(JR, 0, 1, o(0,0,0,0,0,0,0,4,0), 9);
    add(JR, 0, 1, o(0,0,0,0,1,1,2,0,0), 9);
    // illegal opcode: TRAP is terminal, counter frozen
    add(BAD, 0, 1, o(1,0,0,1,1,0,0,0,0), 10);
    add(BAD, 0, 1, o(0,0,0,0,0,0,0,5,0), 10);
    for (int k = 0; k < 20; k++)
      add((k % 2) ? R : LD, k[0], 1, o(0,0,0,0,0,0,0,0,1), 10);
    run_table();

    // Reset asserted between clock edges while MEMWRITE is stalled.
    do_reset();
    add(R, 0, 1, o(0,0,0,0,0,0,0,0,0), 0);
    add_rtype(0);
    add(ST, 0, 1, o(1,0,0,1,1,0,0,0,0), 1);
    add(ST, 0, 1, o(0,0,0,0,0,0,0,5,0), 1);
    add(ST, 0, 1, o(0,0,0,0,0,0,0,4,0), 1);
    add(ST, 0, 0, o(1,1,1,0,0,0,0,0,0), 1);
    run_table();
    #2 resetn = 1'b0;
    #1;
    check("midwrite_mem_req", {63'd0, m32.mem_req}, 64'd0);
    check("midwrite_mem_we",  {63'd0, m32.mem_we},  64'd0);
    check("midwrite_retired", {32'd0, retired},     64'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    add(ST, 0, 1, o(0,0,0,0,0,0,0,0,0), 0);
    add(ST, 0, 1, o(1,0,0,1,1,0,0,0,0), 0);
    run_table();

    // 17 back-to-back ALU instructions; the 4-bit counter wraps.
    do_reset();
    add(R, 0, 1, o(0,0,0,0,0,0,0,0,0), 0);
    run_table();
    for (int k = 0; k <= 17; k++) begin
      if (k < 17) add_rtype(k);
      else        add(R, 0, 1, o(1,0,0,1,1,0,0,0,0), 17);
      step(tbl.pop_front());
      if (k >= 15)
        check($sformatf("cnt4_after_%0d", k), {60'd0, retired4}, 64'(k % 16));
      run_table();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
